// File: rtl/uart_cpu_top_if.sv
// Pin bundle for uart_cpu_top: run control, serial lines and the store-observation outputs.
interface uart_cpu_top_if;
   logic        run;
   logic        uart_rx;
   logic        uart_tx;
   logic [31:0] writedata;
   logic [31:0] dataadr;
   logic        memwrite;

   modport slave (input run, uart_rx, output uart_tx, writedata, dataadr, memwrite);
   modport master (output run, uart_rx, input uart_tx, writedata, dataadr, memwrite);
endinterface

// File: rtl/uart_cpu_top.sv
// MIPS-subset single-cycle CPU with an 8N1 UART loader (imem writes) and register read-back.
// Define UART_WRITE_ACK_EN to transmit 0x06 after every completed imem write command.
module uart_cpu_top #(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned BAUD   = 9600
) (
   input logic           clk,
   input logic           reset,
   uart_cpu_top_if.slave bus
);
   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic {TxIdle, TxSend} tx_state_e;
   typedef enum logic {CmdIdle, CmdData} cmd_state_e;

   logic [31:0] imem [128];
   logic [31:0] regs [32];

   // ---------------- UART receiver ----------------
   rx_state_e   rx_state_q, rx_state_d;
   logic        rx_meta_q, rx_sync_q, rx_valid;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_meta_q  <= bus.uart_rx;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid   = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (!rx_sync_q) rx_state_d = RxStart;
         end
         RxStart: if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RxIdle : RxData;
         end
         RxData: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
         end
         RxStop: if (rx_cnt_q == BIT_LAST) begin
            rx_valid   = rx_sync_q;  // framing error drops the byte
            rx_state_d = RxIdle;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // ---------------- UART transmitter ----------------
   tx_state_e   tx_state_q, tx_state_d;
   logic [9:0]  tx_frame_q, tx_frame_d;
   logic [3:0]  tx_bit_q, tx_bit_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic        tx_start;
   logic [7:0]  tx_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= TxIdle;
         tx_frame_q <= '1;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_frame_q <= tx_frame_d;
         tx_bit_q   <= tx_bit_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_frame_d = tx_frame_q;
      tx_bit_d   = tx_bit_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      unique case (tx_state_q)
         TxIdle: begin
            tx_cnt_d = '0;
            if (tx_start) begin
               tx_frame_d = {1'b1, tx_byte, 1'b0};
               tx_bit_d   = '0;
               tx_state_d = TxSend;
            end
         end
         TxSend: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d   = '0;
            tx_frame_d = {1'b1, tx_frame_q[9:1]};
            if (tx_bit_q == 4'd9) tx_state_d = TxIdle;
            else                  tx_bit_d   = tx_bit_q + 4'd1;
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   assign bus.uart_tx = (tx_state_q == TxSend) ? tx_frame_q[0] : 1'b1;

   // ---------------- Command parser ----------------
   cmd_state_e  cmd_state_q, cmd_state_d;
   logic [6:0]  cmd_addr_q, cmd_addr_d;
   logic [1:0]  cmd_cnt_q, cmd_cnt_d;
   logic [31:0] cmd_data_q, cmd_data_d;
   logic        read_req, write_done;
   logic        imem_we_q;
   logic [6:0]  imem_wa_q;
   logic [31:0] imem_wd_q;

   always_comb begin
      cmd_state_d = cmd_state_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_cnt_d   = cmd_cnt_q;
      cmd_data_d  = cmd_data_q;
      read_req    = 1'b0;
      write_done  = 1'b0;
      if (rx_valid) begin
         unique case (cmd_state_q)
            CmdIdle: begin
               if (rx_shift_q[7]) begin
                  cmd_state_d = CmdData;
                  cmd_addr_d  = rx_shift_q[6:0];
                  cmd_cnt_d   = '0;
               end else begin
                  read_req = 1'b1;
               end
            end
            CmdData: begin
               cmd_data_d = {rx_shift_q, cmd_data_q[31:8]};
               cmd_cnt_d  = cmd_cnt_q + 2'd1;
               if (cmd_cnt_q == 2'd3) begin
                  write_done  = 1'b1;
                  cmd_state_d = CmdIdle;
               end
            end
            default: cmd_state_d = CmdIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_state_q <= CmdIdle;
         cmd_addr_q  <= '0;
         cmd_cnt_q   <= '0;
         cmd_data_q  <= '0;
         imem_we_q   <= 1'b0;
         imem_wa_q   <= '0;
         imem_wd_q   <= '0;
      end else begin
         cmd_state_q <= cmd_state_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_cnt_q   <= cmd_cnt_d;
         cmd_data_q  <= cmd_data_d;
         imem_we_q   <= write_done;
         imem_wa_q   <= cmd_addr_q;
         imem_wd_q   <= cmd_data_d;
      end
   end

   // imem is deliberately left out of reset so a loaded program survives it
   always_ff @(posedge clk) begin
      if (imem_we_q) imem[imem_wa_q] <= imem_wd_q;
   end

   // ---------------- Response scheduler ----------------
   logic        resp_pend_q, send_now, load_resp, send_ack;
   logic [31:0] resp_word_q, send_word_q;
   logic [2:0]  send_left_q;

   assign send_now  = (tx_state_q == TxIdle) && (send_left_q != 3'd0);
   assign load_resp = (tx_state_q == TxIdle) && (send_left_q == 3'd0) && resp_pend_q;
`ifdef UART_WRITE_ACK_EN
   logic ack_pend_q;
   assign send_ack = (tx_state_q == TxIdle) && (send_left_q == 3'd0) && !resp_pend_q &&
                     ack_pend_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          ack_pend_q <= 1'b0;
      else if (write_done) ack_pend_q <= 1'b1;
      else if (send_ack)   ack_pend_q <= 1'b0;
   end
`else
   assign send_ack = 1'b0;
`endif
   assign tx_start = send_now || send_ack;
   assign tx_byte  = send_ack ? 8'h06 : send_word_q[7:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_pend_q <= 1'b0;
         resp_word_q <= '0;
         send_word_q <= '0;
         send_left_q <= '0;
      end else begin
         if (send_now) begin
            send_word_q <= send_word_q >> 8;
            send_left_q <= send_left_q - 3'd1;
         end else if (load_resp) begin
            send_word_q <= resp_word_q;
            send_left_q <= 3'd4;
            resp_pend_q <= 1'b0;
         end
         // a read arriving while one is already pending is dropped
         if (read_req && !resp_pend_q) begin
            resp_pend_q <= 1'b1;
            resp_word_q <= regs[rx_shift_q[4:0]];
         end
      end
   end

   // ---------------- Executor ----------------
   logic [6:0]  pc_q;
   logic [31:0] instr, rs_val, rt_val, imm_sext, wr_val, dataadr_q, writedata_q;
   logic [4:0]  wr_addr;
   logic        wr_en, is_sw, memwrite_q, unused_shamt;

   assign instr        = imem[pc_q];
   assign rs_val       = regs[instr[25:21]];
   assign rt_val       = regs[instr[20:16]];
   assign imm_sext     = {{16{instr[15]}}, instr[15:0]};
   assign unused_shamt = ^instr[10:6];

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = instr[20:16];
      wr_val  = rs_val + imm_sext;
      is_sw   = 1'b0;
      case (instr[31:26])
         6'b001000: wr_en = 1'b1;
         6'b000000: begin
            wr_addr = instr[15:11];
            wr_en   = 1'b1;
            case (instr[5:0])
               6'b100000: wr_val = rs_val + rt_val;
               6'b100010: wr_val = rs_val - rt_val;
               6'b100100: wr_val = rs_val & rt_val;
               6'b100101: wr_val = rs_val | rt_val;
               6'b101010: wr_val = {31'd0, $signed(rs_val) < $signed(rt_val)};
               default:   wr_en  = 1'b0;
            endcase
         end
         6'b101011: is_sw = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q        <= '0;
         memwrite_q  <= 1'b0;
         dataadr_q   <= '0;
         writedata_q <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         pc_q       <= bus.run ? pc_q + 7'd1 : 7'd0;
         memwrite_q <= bus.run && is_sw;
         if (bus.run && wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= wr_val;
         if (bus.run && is_sw) begin
            dataadr_q   <= rs_val + imm_sext;
            writedata_q <= rt_val;
         end
      end
   end

   assign bus.memwrite  = memwrite_q;
   assign bus.dataadr   = dataadr_q;
   assign bus.writedata = writedata_q;
endmodule

// File: tb/tb_uart_cpu_top.sv
// Bench for uart_cpu_top: UART host driver/monitor plus an instruction-level CPU reference model.
module tb_uart_cpu_top;
  localparam int unsigned CLK_HZ = 800;
  localparam int unsigned BAUD   = 100;
  localparam int          CPB    = 8;
`ifdef UART_WRITE_ACK_EN
  localparam int ACKS = 1;
`else
  localparam int ACKS = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  uart_cpu_top_if bus ();

  uart_cpu_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  txq[$];
  logic [7:0]  mb;
  int          mw_count = 0;
  logic [31:0] mw_adr, mw_data;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [128];
  int          m_mw_count = 0;
  logic [31:0] m_adr, m_data;

  // Serial receiver watching uart_tx, sampling at bit centres
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mb[i] = bus.uart_tx;
        end
        repeat (CPB) @(negedge clk);
        txq.push_back(mb);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.memwrite === 1'b1) begin
        mw_count++;
        mw_adr  = bus.dataadr;
        mw_data = bus.writedata;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  // ISA-level semantics of one instruction
  function automatic void model_step(input logic [31:0] ins);
    logic [31:0] a, b, imm, res;
    logic signed [15:0] s16;
    int dst;
    a   = m_regs[ins[25:21]];
    b   = m_regs[ins[20:16]];
    s16 = ins[15:0];
    imm = 32'(s16);
    dst = -1;
    res = '0;
    if (ins[31:26] == 6'd8) begin
      dst = int'(ins[20:16]);
      res = a + imm;
    end else if (ins[31:26] == 6'd0) begin
      dst = int'(ins[15:11]);
      case (ins[5:0])
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: dst = -1;
      endcase
    end else if (ins[31:26] == 6'h2b) begin
      m_mw_count++;
      m_adr  = a + imm;
      m_data = b;
    end
    if (dst > 0) m_regs[dst] = res;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endfunction

  // Returns the number of 0x06 bytes received, or -1 if anything else arrived
  function automatic int drain_acks();
    int n;
    bit bad;
    logic [7:0] b;
    n   = 0;
    bad = 1'b0;
    while (txq.size() > 0) begin
      b = txq.pop_front();
      if (b == 8'h06) n++;
      else bad = 1'b1;
    end
    return bad ? -1 : n;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop) begin
      bus.uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      bus.uart_rx = 1'b0;
      repeat (CPB / 2 + 1) @(negedge clk);
      bus.uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    while (txq.size() == 0 && t < 30 * CPB) begin
      @(negedge clk);
      t++;
    end
    ok = (txq.size() != 0);
    b  = ok ? txq.pop_front() : 8'hxx;
  endtask

  task automatic write_word(input logic [6:0] a, input logic [31:0] d);
    send_byte({1'b1, a}, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    m_imem[a] = d;
  endtask

  // Upper address bits are randomised since the register index ignores them
  task automatic read_reg(input logic [4:0] r, output logic [31:0] w);
    logic [7:0] b;
    bit ok;
    logic [1:0] hi;
    hi = 2'($urandom_range(0, 3));
    send_byte({1'b0, hi, r}, 1'b1);
    w = '0;
    for (int i = 0; i < 4; i++) begin
      get_byte(b, ok);
      if (!ok) begin
        w = 'x;
        return;
      end
      w[8*i +: 8] = b;
    end
  endtask

  task automatic run_cycles(input int k);
    @(negedge clk);
    bus.run = 1'b1;
    repeat (k) @(negedge clk);
    bus.run = 1'b0;
    for (int p = 0; p < k; p++) model_step(m_imem[p % 128]);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    txq.delete();
    model_reset();
  endtask

  task automatic test_reset();
    bus.run = 1'b0;
    bus.uart_rx = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.uart_tx !== 1'b1) begin
      errors++; $display("FAIL reset_uart_tx: got %b expected 1", bus.uart_tx);
    end
    checks++;
    if (bus.memwrite !== 1'b0) begin
      errors++; $display("FAIL reset_memwrite: got %b expected 0", bus.memwrite);
    end
    checks++;
    if (bus.writedata !== 32'h0) begin
      errors++; $display("FAIL reset_writedata: got %h expected 0", bus.writedata);
    end
    checks++;
    if (bus.dataadr !== 32'h0) begin
      errors++; $display("FAIL reset_dataadr: got %h expected 0", bus.dataadr);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.uart_tx !== 1'b1) begin
      errors++; $display("FAIL idle_uart_tx: got %b expected 1", bus.uart_tx);
    end
    model_reset();
  endtask

  task automatic test_read_after_reset();
    logic [31:0] w;
    logic [4:0] r;
    for (int i = 0; i < 6; i++) begin
      r = (i == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      read_reg(r, w);
      checks++;
      if (w !== 32'h0) begin
        errors++; $display("FAIL read_after_reset r%0d: got %h expected 00000000", r, w);
      end
    end
  endtask

  task automatic test_addi_load();
    logic [31:0] w;
    int n;
    for (int j = 0; j < 32; j++) write_word(7'(j), enc_i(6'd8, 5'd0, 5'(j), 16'(j)));
    repeat (15 * CPB) @(negedge clk);
    n = drain_acks();
    checks++;
    if (n != 32 * ACKS) begin
      errors++; $display("FAIL addi_write_ack: got %0d acks expected %0d", n, 32 * ACKS);
    end
    run_cycles(32);
    for (int j = 0; j < 32; j++) begin
      read_reg(5'(j), w);
      checks++;
      if (w !== 32'(j)) begin
        errors++; $display("FAIL addi_read r%0d: got %h expected %h", j, w, 32'(j));
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, b, c;
    logic [7:0] bt;
    bit ok;
    logic [31:0] w1, w2;
    a = $urandom_range(1, 31);
    b = a % 31 + 1;
    c = b % 31 + 1;
    send_byte(8'(a), 1'b1);
    send_byte(8'(b), 1'b1);
    send_byte(8'(c), 1'b1);
    for (int i = 0; i < 8; i++) begin
      get_byte(bt, ok);
      if (i < 4) w1[8*i +: 8] = ok ? bt : 8'hxx;
      else       w2[8*(i-4) +: 8] = ok ? bt : 8'hxx;
    end
    checks++;
    if (w1 !== m_regs[a]) begin
      errors++; $display("FAIL b2b_first r%0d: got %h expected %h", a, w1, m_regs[a]);
    end
    checks++;
    if (w2 !== m_regs[b]) begin
      errors++; $display("FAIL b2b_second r%0d: got %h expected %h", b, w2, m_regs[b]);
    end
    repeat (60 * CPB) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      errors++; $display("FAIL b2b_third_dropped: got %0d extra bytes expected 0", txq.size());
    end
    txq.delete();
  endtask

  task automatic test_sw();
    int mw0, n;
    logic [31:0] w;
    write_word(7'd0, enc_i(6'd8, 5'd0, 5'd1, 16'hffff));
    write_word(7'd1, enc_i(6'h2b, 5'd0, 5'd1, 16'd4));
    repeat (15 * CPB) @(negedge clk);
    n = drain_acks();
    checks++;
    if (n != 2 * ACKS) begin
      errors++; $display("FAIL sw_write_ack: got %0d acks expected %0d", n, 2 * ACKS);
    end
    mw0 = mw_count;
    run_cycles(2);
    checks++;
    if (mw_count - mw0 != 1) begin
      errors++; $display("FAIL sw_pulse_count: got %0d expected 1", mw_count - mw0);
    end
    checks++;
    if (mw_adr !== 32'd4) begin
      errors++; $display("FAIL sw_dataadr: got %h expected 00000004", mw_adr);
    end
    checks++;
    if (mw_data !== 32'hffffffff) begin
      errors++; $display("FAIL sw_writedata: got %h expected ffffffff", mw_data);
    end
    read_reg(5'd1, w);
    checks++;
    if (w !== 32'hffffffff) begin
      errors++; $display("FAIL sw_read_r1: got %h expected ffffffff", w);
    end
  endtask

  task automatic test_bad_stop();
    logic [31:0] w;
    send_byte(8'h85, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (50 * CPB) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      errors++; $display("FAIL bad_stop_silent: got %0d bytes expected 0", txq.size());
    end
    txq.delete();
    read_reg(5'd2, w);
    checks++;
    if (w !== m_regs[2]) begin
      errors++; $display("FAIL bad_stop_next_read: got %h expected %h", w, m_regs[2]);
    end
  endtask

  task automatic test_random_program();
    logic [31:0] ins, w;
    logic [4:0] rd, rs, rt;
    logic [15:0] imm;
    int n;
    logic [5:0] fn [5];
    fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25; fn[4] = 6'h2a;
    for (int it = 0; it < 2; it++) begin
      for (int p = 0; p < 16; p++) begin
        rd  = 5'($urandom_range(0, 7));
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
          0, 1:    ins = enc_i(6'd8, rs, rt, imm);
          2:       ins = enc_r(rd, rs, rt, fn[0]);
          3:       ins = enc_r(rd, rs, rt, fn[1]);
          4:       ins = enc_r(rd, rs, rt, fn[2]);
          5:       ins = enc_r(rd, rs, rt, fn[3]);
          6:       ins = enc_r(rd, rs, rt, fn[4]);
          7:       ins = enc_i(6'h2b, rs, rt, imm);
          8:       ins = enc_r(rd, rs, rt, 6'h21);
          default: ins = enc_i(6'h23, rs, rt, imm);
        endcase
        write_word(7'(p), ins);
      end
      repeat (15 * CPB) @(negedge clk);
      n = drain_acks();
      checks++;
      if (n != 16 * ACKS) begin
        errors++; $display("FAIL rand_write_ack it%0d: got %0d expected %0d", it, n, 16 * ACKS);
      end
      run_cycles(16);
      checks++;
      if (mw_count != m_mw_count) begin
        errors++; $display("FAIL rand_sw_count it%0d: got %0d expected %0d", it, mw_count,
                           m_mw_count);
      end
      if (m_mw_count > 0) begin
        checks++;
        if (mw_adr !== m_adr || mw_data !== m_data) begin
          errors++; $display("FAIL rand_sw_last it%0d: got %h/%h expected %h/%h", it, mw_adr,
                             mw_data, m_adr, m_data);
        end
      end
      for (int r = 0; r < 8; r++) begin
        read_reg(5'(r), w);
        checks++;
        if (w !== m_regs[r]) begin
          errors++; $display("FAIL rand_read it%0d r%0d: got %h expected %h", it, r, w,
                             m_regs[r]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    logic [4:0] r;
    int n;
    send_byte(8'h82, 1'b1);
    send_byte(8'hab, 1'b1);
    pulse_reset();
    r = 5'($urandom_range(1, 31));
    read_reg(r, w);
    checks++;
    if (w !== 32'h0) begin
      errors++; $display("FAIL reset_mid_read r%0d: got %h expected 00000000", r, w);
    end
    run_cycles(4);
    for (int i = 0; i < 8; i++) begin
      read_reg(5'(i), w);
      checks++;
      if (w !== m_regs[i]) begin
        errors++; $display("FAIL reset_mid_imem r%0d: got %h expected %h", i, w, m_regs[i]);
      end
    end
    repeat (15 * CPB) @(negedge clk);
    n = drain_acks();
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL reset_mid_no_ack: got %0d expected 0", n);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_imem[i] = 'x;
    test_reset();
    test_read_after_reset();
    test_addi_load();
    test_back_to_back();
    test_sw();
    test_bad_stop();
    test_random_program();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
